// File: rtl/pipelined_matrix_mult.sv
// pipelined_matrix_mult: 3x3 unsigned 8-bit matrix product, three-stage
// free-running pipeline (register, multiply, accumulate), one result per clock.
module pipelined_matrix_mult (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  input  logic [7:0] a4,
  input  logic [7:0] a5,
  input  logic [7:0] a6,
  input  logic [7:0] a7,
  input  logic [7:0] a8,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] b3,
  input  logic [7:0] b4,
  input  logic [7:0] b5,
  input  logic [7:0] b6,
  input  logic [7:0] b7,
  input  logic [7:0] b8,
  output logic [7:0] c0,
  output logic [7:0] c1,
  output logic [7:0] c2,
  output logic [7:0] c3,
  output logic [7:0] c4,
  output logic [7:0] c5,
  output logic [7:0] c6,
  output logic [7:0] c7,
  output logic [7:0] c8,
  output logic       done
);

  logic [8:0][7:0]   a_d, a_q;
  logic [8:0][7:0]   b_d, b_q;
  logic [26:0][15:0] p_d, p_q;
  logic [8:0][17:0]  sum;
  logic [8:0][9:0]   unused_hi;
  logic [8:0][7:0]   c_d, c_q;
  logic [2:0]        vld_d, vld_q;

  assign a_d = {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  assign b_d = {b8, b7, b6, b5, b4, b3, b2, b1, b0};

  // Product index (i*3+j)*3+k holds A[i][k]*B[k][j]
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      for (genvar k = 0; k < 3; k++) begin : g_k
        assign p_d[(i*3+j)*3+k] =
          16'(a_q[i*3+k]) * 16'(b_q[k*3+j]);
      end
    end
  end

  // Only the low byte is kept; the result wraps modulo 256
  for (genvar e = 0; e < 9; e++) begin : g_acc
    assign sum[e] = 18'(p_q[e*3])
                  + 18'(p_q[e*3+1])
                  + 18'(p_q[e*3+2]);
    assign c_d[e]       = sum[e][7:0];
    assign unused_hi[e] = sum[e][17:8];
  end

  assign vld_d = {vld_q[1:0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      c_q   <= '0;
      vld_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign c0   = c_q[0];
  assign c1   = c_q[1];
  assign c2   = c_q[2];
  assign c3   = c_q[3];
  assign c4   = c_q[4];
  assign c5   = c_q[5];
  assign c6   = c_q[6];
  assign c7   = c_q[7];
  assign c8   = c_q[8];
  assign done = vld_q[2];

endmodule

// File: tb/tb_pipelined_matrix_mult.sv
// tb_pipelined_matrix_mult: directed and random checks of the
// pipelined 3x3 matrix multiplier with immediate assertions.
module tb_pipelined_matrix_mult;

  typedef logic [8:0][7:0] mat_t;

  logic clk;
  logic rst;
  mat_t av, bv;
  logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
  logic done;
  mat_t cv;

  int checks;
  int failures;

  assign cv = {c8, c7, c6, c5, c4, c3, c2, c1, c0};

  pipelined_matrix_mult dut (
    .clk  (clk),
    .rst  (rst),
    .a0   (av[0]), .a1(av[1]), .a2(av[2]),
    .a3   (av[3]), .a4(av[4]), .a5(av[5]),
    .a6   (av[6]), .a7(av[7]), .a8(av[8]),
    .b0   (bv[0]), .b1(bv[1]), .b2(bv[2]),
    .b3   (bv[3]), .b4(bv[4]), .b5(bv[5]),
    .b6   (bv[6]), .b7(bv[7]), .b8(bv[8]),
    .c0   (c0), .c1(c1), .c2(c2),
    .c3   (c3), .c4(c4), .c5(c5),
    .c6   (c6), .c7(c7), .c8(c8),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mat_t model(input mat_t a, input mat_t b);
    mat_t r;
    int s;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(a[i*3+k]) * int'(b[k*3+j]);
        r[i*3+j] = 8'(s % 256);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input mat_t exp);
    for (int e = 0; e < 9; e++)
      chk($sformatf("%s_c%0d", tag, e), 32'(cv[e]), 32'(exp[e]));
  endtask

  task automatic set_seq(output mat_t m, input int start, input int dir);
    for (int e = 0; e < 9; e++)
      m[e] = 8'(start + dir * e);
  endtask

  mat_t ref_exp, ident, m, e;
  mat_t q[$];

  initial begin
    checks   = 0;
    failures = 0;
    ref_exp  = '0;
    ident    = '0;
    ident[0] = 8'd1;
    ident[4] = 8'd1;
    ident[8] = 8'd1;
    ref_exp[0] = 8'd30;  ref_exp[1] = 8'd24;  ref_exp[2] = 8'd18;
    ref_exp[3] = 8'd84;  ref_exp[4] = 8'd69;  ref_exp[5] = 8'd54;
    ref_exp[6] = 8'd138; ref_exp[7] = 8'd114; ref_exp[8] = 8'd90;

    // Reference vector with a one-cycle reset
    rst = 1'b0;
    set_seq(av, 1, 1);
    set_seq(bv, 9, -1);
    #7;
    chk("rst_done", 32'(done), 32'd0);
    chk_c("rst", '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ref_e1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("ref_e2_done", 32'(done), 32'd0);
    chk("ref_e2_c0", 32'(c0), 32'd0);
    @(negedge clk);
    chk("ref_e3_done", 32'(done), 32'd1);
    chk_c("ref", ref_exp);

    // Identity times 1..9
    av = ident;
    set_seq(bv, 1, 1);
    repeat (3) @(negedge clk);
    chk_c("ident", bv);

    // All 255: 3*65025 mod 256 = 3
    av = '1;
    bv = '1;
    repeat (3) @(negedge clk);
    m = '0;
    for (int k = 0; k < 9; k++) m[k] = 8'd3;
    chk_c("wrap", m);

    // Back-to-back: A changes every cycle, B = identity
    bv = ident;
    for (int t = 0; t < 8; t++) begin
      if (t >= 3) begin
        for (int k = 0; k < 9; k++) m[k] = 8'(t - 2);
        chk_c($sformatf("b2b%0d", t - 2), m);
        chk("b2b_done", 32'(done), 32'd1);
      end
      if (t < 5)
        for (int k = 0; k < 9; k++) av[k] = 8'(t + 1);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a clock low phase
    set_seq(av, 1, 1);
    set_seq(bv, 9, -1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk_c("mid_rst", '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_e1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("mid_e2_done", 32'(done), 32'd0);
    chk("mid_e2_c4", 32'(c4), 32'd0);
    @(negedge clk);
    chk("mid_e3_done", 32'(done), 32'd1);
    chk_c("mid", ref_exp);

    // Random inputs for 20 cycles; done must hold, C tracks model
    for (int k = 0; k < 3; k++) q.push_back(ref_exp);
    for (int t = 0; t < 23; t++) begin
      e = q.pop_front();
      chk("rnd_done", 32'(done), 32'd1);
      chk_c($sformatf("rnd%0d", t), e);
      if (t < 20) begin
        for (int k = 0; k < 9; k++) begin
          av[k] = 8'($urandom);
          bv[k] = 8'($urandom);
        end
      end
      q.push_back(model(av, bv));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_matrix_mult.md
# pipelined_matrix_mult

Multiplies two 3x3 matrices of unsigned 8-bit elements and produces the 3x3 product (C = A x B), truncated to 8 bits per element. It is a free-running three-stage pipeline: it samples inputs on every clock and delivers one full result matrix per cycle. After reset, `done` indicates that the first valid result has reached the outputs. It sits as a datapath compute block, with its inputs driven by registers or a controller and its outputs read by display or check logic.

## Interface
- No parameters. Element width is fixed at 8 bits and matrix size at 3x3.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting it (low) clears all pipeline state immediately. Release is taken on the following rising edge.
- `a0`..`a8` input 8 each: matrix A, row-major (`a0 a1 a2` = row 0, `a3 a4 a5` = row 1, `a6 a7 a8` = row 2), unsigned.
- `b0`..`b8` input 8 each: matrix B, row-major, unsigned.
- `c0`..`c8` output 8 each: product matrix C, row-major, registered.
- `done` output 1: high once the pipeline holds a valid result; registered.

## Operation
- Each element is Cij = sum over k of Aik*Bkj, with k = 0..2.
  - Example: c0 = a0*b0 + a1*b3 + a2*b6.
  - Example: c4 = a3*b1 + a4*b4 + a5*b7.
- Stage 1 (input register): captures all 18 input elements every cycle.
- Stage 2 (multiply): computes all 27 products Aik*Bkj from the stage-1 registers. Each product is a full-precision 16-bit unsigned value, registered.
- Stage 3 (accumulate/output): adds the three products for each element in 18-bit precision. The low 8 bits are written to `c0`..`c8`, so the result is modulo 256. Higher bits are discarded with no saturation and no overflow flag.
- Valid tracking: a 3-bit valid shift register. Bit 0 loads 1 on every edge out of reset and shifts toward bit 2. `done` equals bit 2.
- Once high, `done` stays high until the next reset. Input changes never clear `done`.
- Inputs may change every cycle. Each output set corresponds exactly to the input set sampled 3 edges earlier; A and B are never mixed from different cycles.
- There is no start/enable handshake. The block computes continuously.

## Timing
- Reset values, while `rst` is low: `c0`..`c8` = 0, `done` = 0, and all stage registers = 0. Outputs clear asynchronously, without waiting for a clock edge.
- Latency is 3 rising edges from input sample to output.
  - Inputs present at edge N appear on `c*` after edge N+2, counting the sampling edge as N.
  - After reset is released, the first valid result and `done`=1 appear after the 3rd rising edge.
- Throughput is one matrix product per clock.
- Reset mid-operation: all in-flight data is discarded and `done` drops asynchronously to 0. After release the full 3-edge latency applies again, and no stale result is flagged as valid.
- Before `done` rises, `c*` show the zero-flushed pipeline contents (0 for zero inputs). Consumers must ignore `c*` until `done`=1.
- An input change on the same edge that `done` rises does not affect the result shown at that edge.

## Test plan
- Reference vector:
  - Stimulus: A = 1..9, B = 9..1, hold rst low for 1 cycle, then release.
  - Required response: `done` rises after the 3rd edge; C rows = 30 24 18 / 84 69 54 / 138 114 90.
- Identity: A = identity, B = 1..9. Required: C = B after 3 edges.
- Overflow wrap: all A and B elements = 255. Required: every c = 3, since 3*65025 = 195075 and 195075 mod 256 = 3.
- Back-to-back throughput:
  - Stimulus: change A/B on every cycle for 5 cycles, holding B = identity and setting A = n*1 in cycle n.
  - Required response: each output equals that cycle's A, exactly 3 edges later, with no gaps or mixing.
- Reset mid-operation:
  - Stimulus: assert `rst` low asynchronously, between clock edges, while `done`=1.
  - Required response: `done` and all `c*` go to 0 immediately; after release, `done` returns only on the 3rd edge and shows the correct product.
- Done persistence: hold `done`=1 while inputs toggle randomly for 20 cycles. Required: `done` never deasserts, and every `c*` matches the reference model delayed by 3 edges.
